pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-beat vector issue sequencing, plus a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int REGI_BITS  = 4,
  parameter int VECT_BITS  = 2,
  parameter int VECT_LANES = 3,
  parameter int VECT_SIZE  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dValid_i,
  input  logic                 dVec_i,
  input  logic [REGI_BITS-1:0] dSrc1_i,
  input  logic [REGI_BITS-1:0] dSrc2_i,
  input  logic [1:0]           dUseSrc_i,
  input  logic                 eValid_i,
  input  logic                 eLoad_i,
  input  logic                 eBranch_i,
  input  logic [REGI_BITS-1:0] eDst_i,
  output logic                 fetch_en_o,
  output logic                 dec_en_o,
  output logic                 dec_flush_o,
  output logic                 ex_bubble_o,
  output logic [VECT_BITS-1:0] vbeat_o,
  output logic                 vlast_o,
  output logic                 busy_o,
  output logic [15:0]          stall_cnt_o
);

  // state | meaning
  // IDLE  | scalar flow; a vector op issues its beat 0 from here
  // VEXEC | vector op in flight, beat counter holds the current beat (1..NB-1)

  localparam int NB = (VECT_SIZE + VECT_LANES - 1) / VECT_LANES;
  localparam logic [VECT_BITS-1:0] LAST_BEAT = VECT_BITS'(NB - 1);
  localparam logic MULTI_BEAT = (NB > 1);

  if (NB < 1 || NB > (1 << VECT_BITS)) begin : g_bad_params
    $error("pipe_ctrl: beat count out of range for VECT_BITS");
  end

  typedef enum logic {IDLE, VEXEC} state_t;

  state_t               state, state_n;
  logic [VECT_BITS-1:0] beat, beat_n;
  logic [15:0]          stall_cnt;
  logic                 load_use;
  logic                 branch;

  assign load_use = dValid_i & eValid_i & eLoad_i &
                    ((dUseSrc_i[0] & (dSrc1_i == eDst_i)) |
                     (dUseSrc_i[1] & (dSrc2_i == eDst_i)));
  assign branch   = eValid_i & eBranch_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      beat      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (!fetch_en_o && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    beat_n      = beat;
    fetch_en_o  = 1'b1;
    dec_en_o    = 1'b1;
    dec_flush_o = 1'b0;
    ex_bubble_o = 1'b0;
    vbeat_o     = '0;
    vlast_o     = 1'b0;
    busy_o      = (state == VEXEC) && !rst_i;

    // Reset cycles present a plain-advance pipe; the register clears next state.
    if (!rst_i) begin
      if (state == VEXEC) begin
        vbeat_o = beat;
      end
      if (branch) begin
        dec_flush_o = 1'b1;
        ex_bubble_o = 1'b1;
        state_n     = IDLE;
        beat_n      = '0;
      end else if (state == VEXEC) begin
        if (beat == LAST_BEAT) begin
          vlast_o = 1'b1;
          state_n = IDLE;
          beat_n  = '0;
        end else begin
          fetch_en_o = 1'b0;
          dec_en_o   = 1'b0;
          beat_n     = beat + VECT_BITS'(1);
        end
      end else if (load_use) begin
        fetch_en_o  = 1'b0;
        dec_en_o    = 1'b0;
        ex_bubble_o = 1'b1;
      end else if (dValid_i && dVec_i) begin
        if (MULTI_BEAT) begin
          fetch_en_o = 1'b0;
          dec_en_o   = 1'b0;
          state_n    = VEXEC;
          beat_n     = VECT_BITS'(1);
        end else begin
          // Single-beat vector op behaves like a scalar that is also its last beat.
          vlast_o = 1'b1;
        end
      end
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios with literal expectations,
// randomized traffic against a behavioural model, and counter saturation.
module tb_pipe_ctrl;

  localparam int REGI_BITS = 4;
  localparam int VECT_BITS = 2;
  localparam int NB        = (8 + 3 - 1) / 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 d_valid, d_vec;
  logic [REGI_BITS-1:0] d_src1, d_src2;
  logic [1:0]           d_use;
  logic                 e_valid, e_load, e_branch;
  logic [REGI_BITS-1:0] e_dst;
  logic                 fetch_en, dec_en, dec_flush, ex_bubble;
  logic [VECT_BITS-1:0] vbeat;
  logic                 vlast, busy;
  logic [15:0]          stall_cnt;

  int checks   = 0;
  int failures = 0;

  // model: m_beat==0 means no vector op in flight, otherwise the current beat
  int m_beat, m_stall, nx_beat, nx_stall;
  int x_fetch, x_dec, x_flush, x_bubble, x_vbeat, x_vlast, x_busy;

  pipe_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dValid_i    (d_valid),
    .dVec_i      (d_vec),
    .dSrc1_i     (d_src1),
    .dSrc2_i     (d_src2),
    .dUseSrc_i   (d_use),
    .eValid_i    (e_valid),
    .eLoad_i     (e_load),
    .eBranch_i   (e_branch),
    .eDst_i      (e_dst),
    .fetch_en_o  (fetch_en),
    .dec_en_o    (dec_en),
    .dec_flush_o (dec_flush),
    .ex_bubble_o (ex_bubble),
    .vbeat_o     (vbeat),
    .vlast_o     (vlast),
    .busy_o      (busy),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    d_valid = 0; d_vec = 0; d_src1 = 0; d_src2 = 0; d_use = 0;
    e_valid = 0; e_load = 0; e_branch = 0; e_dst = 0;
  endtask

  function automatic void model_eval();
    bit lu, br;
    lu = d_valid && e_valid && e_load &&
         ((d_use[0] && d_src1 == e_dst) || (d_use[1] && d_src2 == e_dst));
    br = e_valid && e_branch;
    x_fetch = 1; x_dec = 1; x_flush = 0; x_bubble = 0; x_vbeat = 0; x_vlast = 0;
    x_busy  = (m_beat > 0 && !rst) ? 1 : 0;
    nx_beat = m_beat;
    if (rst) begin
      nx_beat = 0;
    end else begin
      if (m_beat > 0) x_vbeat = m_beat;
      if (br) begin
        x_flush = 1; x_bubble = 1; nx_beat = 0;
      end else if (m_beat > 0) begin
        if (m_beat == NB - 1) begin
          x_vlast = 1; nx_beat = 0;
        end else begin
          x_fetch = 0; x_dec = 0; nx_beat = m_beat + 1;
        end
      end else if (lu) begin
        x_fetch = 0; x_dec = 0; x_bubble = 1;
      end else if (d_valid && d_vec) begin
        if (NB > 1) begin
          x_fetch = 0; x_dec = 0; nx_beat = 1;
        end else begin
          x_vlast = 1;
        end
      end
    end
    if (rst) nx_stall = 0;
    else if (x_fetch == 0) nx_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
    else nx_stall = m_stall;
  endfunction

  // inputs are applied at the negedge; outputs compared 1 time unit later
  task automatic settle();
    #1;
    model_eval();
    chk("fetch_en",  fetch_en,  x_fetch);
    chk("dec_en",    dec_en,    x_dec);
    chk("dec_flush", dec_flush, x_flush);
    chk("ex_bubble", ex_bubble, x_bubble);
    chk("vbeat",     vbeat,     x_vbeat);
    chk("vlast",     vlast,     x_vlast);
    chk("busy",      busy,      x_busy);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic advance();
    @(posedge clk);
    m_beat  = nx_beat;
    m_stall = nx_stall;
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    rst = 1;
    m_beat = 0; m_stall = 0;
    @(negedge clk);

    // reset cycle outputs and reset state
    settle();
    chk("rst_fetch", fetch_en, 1);
    chk("rst_busy", busy, 0);
    advance();
    rst = 0;
    settle();
    chk("reset_stall", stall_cnt, 0);
    chk("reset_vbeat", vbeat, 0);
    advance();

    // load-use: src1 matches load destination
    e_valid = 1; e_load = 1; e_dst = 5; d_valid = 1; d_src1 = 5; d_use = 2'b01;
    settle();
    chk("lu_fetch", fetch_en, 0);
    chk("lu_dec", dec_en, 0);
    chk("lu_bubble", ex_bubble, 1);
    advance();
    clear_in();
    settle();
    chk("lu_stall_after", stall_cnt, 1);
    advance();
    e_valid = 1; e_load = 1; e_dst = 5; d_valid = 1; d_src1 = 5; d_use = 2'b00;
    settle();
    chk("nouse_fetch", fetch_en, 1);
    chk("nouse_bubble", ex_bubble, 0);
    advance();
    clear_in();

    // vector op, three beats
    d_valid = 1; d_vec = 1;
    settle();
    chk("v0_vbeat", vbeat, 0); chk("v0_busy", busy, 0); chk("v0_fetch", fetch_en, 0);
    chk("v0_vlast", vlast, 0);
    advance();
    settle();
    chk("v1_vbeat", vbeat, 1); chk("v1_busy", busy, 1); chk("v1_fetch", fetch_en, 0);
    chk("v1_vlast", vlast, 0);
    advance();
    settle();
    chk("v2_vbeat", vbeat, 2); chk("v2_busy", busy, 1); chk("v2_fetch", fetch_en, 1);
    chk("v2_vlast", vlast, 1);
    advance();
    clear_in();
    settle();
    chk("vec_stall", stall_cnt, 3);
    chk("vec_done_busy", busy, 0);
    advance();

    // branch at beat 1
    d_valid = 1; d_vec = 1;
    settle();
    advance();
    e_valid = 1; e_branch = 1;
    settle();
    chk("br_flush", dec_flush, 1); chk("br_bubble", ex_bubble, 1); chk("br_fetch", fetch_en, 1);
    advance();
    clear_in();
    settle();
    chk("br_after_busy", busy, 0); chk("br_after_vbeat", vbeat, 0);
    chk("br_stall", stall_cnt, 4);
    advance();

    // branch together with load-use
    e_valid = 1; e_load = 1; e_branch = 1; e_dst = 5; d_valid = 1; d_src1 = 5; d_use = 2'b01;
    settle();
    chk("brlu_flush", dec_flush, 1); chk("brlu_bubble", ex_bubble, 1);
    chk("brlu_fetch", fetch_en, 1);
    advance();
    clear_in();
    settle();
    chk("brlu_stall", stall_cnt, 4);
    advance();

    // reset at beat 1
    d_valid = 1; d_vec = 1;
    settle();
    advance();
    rst = 1;
    settle();
    chk("rstv_busy", busy, 0); chk("rstv_fetch", fetch_en, 1); chk("rstv_vbeat", vbeat, 0);
    advance();
    rst = 0;
    clear_in();
    settle();
    chk("rstv_after_busy", busy, 0); chk("rstv_after_stall", stall_cnt, 0);
    advance();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      d_valid  = $urandom_range(0, 3) != 0;
      d_vec    = $urandom_range(0, 1);
      d_src1   = REGI_BITS'($urandom_range(0, 3));
      d_src2   = REGI_BITS'($urandom_range(0, 3));
      d_use    = 2'($urandom_range(0, 3));
      e_valid  = $urandom_range(0, 3) != 0;
      e_load   = $urandom_range(0, 1);
      e_branch = ($urandom_range(0, 7) == 0);
      e_dst    = REGI_BITS'($urandom_range(0, 3));
      settle();
      advance();
    end

    // saturation: continuous load-use stall
    clear_in();
    rst = 1;
    settle();
    advance();
    rst = 0;
    e_valid = 1; e_load = 1; e_dst = 5; d_valid = 1; d_src1 = 5; d_use = 2'b01;
    for (int i = 0; i < 65540; i++) begin
      settle();
      advance();
    end
    clear_in();
    settle();
    chk("sat_stall", stall_cnt, 16'hFFFF);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
